// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among NREQ clients: sequences start,
// routes data_rdy/data_out back to the granted client and drives per-client chip select.
module spi_master_arbiter #(
    parameter int unsigned NW       = 2,
    parameter int unsigned Nd       = 3,
    parameter int unsigned Nc       = 6,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [(1<<NW)-1:0]       req,
    input  logic [(1<<NW)*Nc-1:0]    req_cyc_count,
    input  logic [(1<<NW)*(1<<Nd)-1:0] req_data_in,
    output logic [(1<<NW)-1:0]       gnt,
    output logic [NW-1:0]            gnt_idx,
    output logic [(1<<NW)-1:0]       cl_data_rdy,
    output logic [(1<<Nd)-1:0]       cl_data_out,
    output logic [Nc-1:0]            cl_cyc_num,
    output logic [(1<<NW)-1:0]       done,
    output logic                     err,
    output logic                     m_start,
    output logic [Nc-1:0]            m_cyc_count,
    output logic [(1<<Nd)-1:0]       m_data_in,
    input  logic [(1<<Nd)-1:0]       m_data_out,
    input  logic [Nc-1:0]            m_cyc_num,
    input  logic                     m_data_rdy,
    input  logic                     m_busy,
    input  logic                     m_spi_cs,
    output logic [(1<<NW)-1:0]       spi_cs_n
);

    localparam int unsigned NREQ = 1 << NW;
    localparam int unsigned N    = 1 << Nd;
    localparam int unsigned CW   = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        RUN,
        DONE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [NW-1:0]   last, last_next;
    logic [NREQ-1:0] gnt_next;
    logic [NW-1:0]   gnt_idx_next;
    logic            start_next;
    logic [NREQ-1:0] done_next;
    logic            err_next;

    logic [Nc-1:0]   cc_arr [NREQ];
    logic [N-1:0]    di_arr [NREQ];
    logic            found;
    logic [NW-1:0]   pick_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign cc_arr[i] = req_cyc_count[i*Nc +: Nc];
        assign di_arr[i] = req_data_in[i*N +: N];
    end

    // Round-robin pick: scan last+1, last+2, ... wrapping, last itself checked last.
    always_comb begin
        found    = 1'b0;
        pick_idx = last;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[NW'(last + NW'(i))]) begin
                found    = 1'b1;
                pick_idx = NW'(last + NW'(i));
            end
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        last_next    = last;
        gnt_next     = gnt;
        gnt_idx_next = gnt_idx;
        start_next   = 1'b0;
        done_next    = '0;
        err_next     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_next     = NREQ'(1) << pick_idx;
                    gnt_idx_next = pick_idx;
                    if (cc_arr[pick_idx] == '0) begin
                        state_next = DONE;
                        done_next  = NREQ'(1) << pick_idx;
                    end else begin
                        state_next = START;
                        start_next = 1'b1;
                    end
                end
            end
            START: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end
            WAIT_BUSY: begin
                if (m_busy) begin
                    state_next = RUN;
                end else if (cnt == CW'(WAIT_MAX)) begin
                    state_next = DONE;
                    done_next  = gnt;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!m_busy) begin
                    state_next = DONE;
                    done_next  = gnt;
                end
            end
            DONE: begin
                state_next = IDLE;
                last_next  = gnt_idx;
                gnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // m_start/done/err are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= NW'(NREQ - 1);
            gnt     <= '0;
            gnt_idx <= '0;
            m_start <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            last    <= last_next;
            gnt     <= gnt_next;
            gnt_idx <= gnt_idx_next;
            m_start <= start_next;
            done    <= done_next;
            err     <= err_next;
        end
    end

    assign m_cyc_count = (gnt != '0) ? cc_arr[gnt_idx] : '0;
    assign m_data_in   = (gnt != '0) ? di_arr[gnt_idx] : '0;
    assign cl_data_rdy = gnt & {NREQ{m_data_rdy}};
    assign cl_data_out = m_data_out;
    assign cl_cyc_num  = m_cyc_num;
    assign spi_cs_n    = ~gnt | {NREQ{m_spi_cs}};

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a small loopback spi_master model.
module tb_spi_master_arbiter;

    localparam int NREQ     = 4;
    localparam int N        = 8;
    localparam int Nc       = 6;
    localparam int WAIT_MAX = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [NREQ*Nc-1:0] req_cyc_count;
    logic [NREQ*N-1:0]  req_data_in;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic [NREQ-1:0] cl_data_rdy;
    logic [N-1:0]    cl_data_out;
    logic [Nc-1:0]   cl_cyc_num;
    logic [NREQ-1:0] done;
    logic            err;
    logic            m_start;
    logic [Nc-1:0]   m_cyc_count;
    logic [N-1:0]    m_data_in;
    logic [N-1:0]    m_data_out;
    logic [Nc-1:0]   m_cyc_num;
    logic            m_data_rdy;
    logic            m_busy;
    logic            m_spi_cs;
    logic [NREQ-1:0] spi_cs_n;

    int checks   = 0;
    int failures = 0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    spi_master_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_cyc_count(req_cyc_count),
        .req_data_in(req_data_in), .gnt(gnt), .gnt_idx(gnt_idx),
        .cl_data_rdy(cl_data_rdy), .cl_data_out(cl_data_out), .cl_cyc_num(cl_cyc_num),
        .done(done), .err(err), .m_start(m_start), .m_cyc_count(m_cyc_count),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_cyc_num(m_cyc_num),
        .m_data_rdy(m_data_rdy), .m_busy(m_busy), .m_spi_cs(m_spi_cs), .spi_cs_n(spi_cs_n)
    );

    // Loopback spi_master: one word every 4 clk, echoes data_in, reloads a cycle after data_rdy.
    logic [N-1:0]  shreg;
    logic [Nc-1:0] left;
    logic [1:0]    tmr;
    logic          reload;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_spi_cs <= 1'b1; m_data_rdy <= 1'b0; reload <= 1'b0;
            shreg <= '0; m_data_out <= '0; m_cyc_num <= '0; left <= '0; tmr <= '0;
        end else begin
            m_data_rdy <= 1'b0;
            if (reload) begin
                shreg  <= m_data_in;
                reload <= 1'b0;
            end
            if (!m_busy) begin
                if (m_start && !stall) begin
                    m_busy <= 1'b1; m_spi_cs <= 1'b0; left <= m_cyc_count;
                    shreg <= m_data_in; tmr <= '0; m_cyc_num <= '0;
                end
            end else begin
                tmr <= tmr + 2'd1;
                if (tmr == 2'd3) begin
                    m_data_rdy <= 1'b1;
                    m_data_out <= shreg;
                    m_cyc_num  <= m_cyc_num + 6'd1;
                    reload     <= 1'b1;
                    left       <= left - 6'd1;
                    if (left == 6'd1) begin
                        m_busy   <= 1'b0;
                        m_spi_cs <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_cyc_count = '0; req_data_in = '0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (gnt_idx !== 2'd0) begin failures++; $display("FAIL reset_gnt_idx: got %0d expected 0", gnt_idx); end
        checks++; if ({m_start, done, err} !== 6'b0) begin failures++; $display("FAIL reset_strobes: got %b expected 000000", {m_start, done, err}); end
        checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL reset_cs: got %h expected f", spi_cs_n); end
        checks++; if ({m_cyc_count, m_data_in} !== 14'd0) begin failures++; $display("FAIL reset_mux: got %h expected 0", {m_cyc_count, m_data_in}); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [N-1:0] tx [3];
        logic [N-1:0] rx [3];
        int k = 0, starts = 0, dones = 0, cs_seen = 0, cs_bad = 0, other = 0;
        tx = '{8'hA5, 8'h3C, 8'hF0};
        rx = '{8'h00, 8'h00, 8'h00};
        req_cyc_count[2*Nc +: Nc] = 6'd3;
        req_data_in[2*N +: N] = tx[0];
        req[2] = 1'b1;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            @(negedge clk);
            if (m_start) starts++;
            if ((cl_data_rdy & 4'b1011) != 4'b0) other++;
            if (!m_spi_cs) begin
                cs_seen++;
                if (spi_cs_n !== 4'b1011) cs_bad++;
            end
            if (cl_data_rdy[2]) begin
                if (k < 3) rx[k] = cl_data_out;
                k++;
                if (k < 3) req_data_in[2*N +: N] = tx[k];
            end
            if (done[2]) begin
                dones++;
                req[2] = 1'b0;
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (done != 4'b0) dones++;
            if (m_start) starts++;
        end
        checks++; if (starts != 1) begin failures++; $display("FAIL single_starts: got %0d expected 1", starts); end
        checks++; if (k != 3) begin failures++; $display("FAIL single_rdy_count: got %0d expected 3", k); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx[i] !== tx[i]) begin failures++; $display("FAIL single_rx%0d: got %h expected %h", i, rx[i], tx[i]); end
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", dones); end
        checks++; if (cs_bad != 0 || cs_seen == 0) begin failures++; $display("FAIL single_cs: bad=%0d seen=%0d expected bad=0 seen>0", cs_bad, cs_seen); end
        checks++; if (other != 0) begin failures++; $display("FAIL single_other_rdy: got %0d expected 0", other); end
    endtask

    task automatic test_contention();
        int order [5];
        int nd = 0, overlap = 0;
        order = '{-1, -1, -1, -1, -1};
        do_reset();
        for (int i = 0; i < NREQ; i++) req_cyc_count[i*Nc +: Nc] = 6'd1;
        req = 4'hF;
        for (int c = 0; c < 400 && nd < 5; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) overlap++;
            if ($countones(~spi_cs_n) > 1) overlap++;
            for (int i = 0; i < NREQ; i++)
                if (done[i] && nd < 5) begin
                    order[nd] = i;
                    nd++;
                    if (nd == 5) req = 4'h0;
                end
        end
        req = 4'h0;
        repeat (4) @(negedge clk);
        checks++; if (nd != 5) begin failures++; $display("FAIL cont_count: got %0d expected 5", nd); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (order[i] != i % 4) begin failures++; $display("FAIL cont_order%0d: got %0d expected %0d", i, order[i], i % 4); end
        end
        checks++; if (overlap != 0) begin failures++; $display("FAIL cont_overlap: got %0d expected 0", overlap); end
    endtask

    task automatic test_fairness();
        int first = -1, second = -1, nd = 0;
        bit seen = 0;
        req_cyc_count[0 +: Nc] = 6'd1;
        req_cyc_count[3*Nc +: Nc] = 6'd1;
        req[0] = 1'b1;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (gnt[0]) seen = 1;
        end
        req[3] = 1'b1;
        for (int c = 0; c < 200 && nd < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (done[i]) begin
                    if (nd == 0) first = i; else second = i;
                    nd++;
                end
            if (nd == 2) req = 4'h0;
        end
        req = 4'h0;
        repeat (4) @(negedge clk);
        checks++; if (!seen) begin failures++; $display("FAIL fair_grant0: got no grant expected gnt[0]"); end
        checks++; if (first != 0) begin failures++; $display("FAIL fair_first: got %0d expected 0", first); end
        checks++; if (second != 3) begin failures++; $display("FAIL fair_second: got %0d expected 3", second); end
    endtask

    task automatic test_zero_count();
        int at = 0, starts = 0;
        logic e = 1'b1;
        req_cyc_count[1*Nc +: Nc] = 6'd0;
        req[1] = 1'b1;
        for (int c = 1; c <= 3 && at == 0; c++) begin
            @(negedge clk);
            if (m_start) starts++;
            if (done[1]) begin
                at = c;
                e = err;
                req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_start) starts++;
        end
        checks++; if (at == 0) begin failures++; $display("FAIL zero_done: got none within 3 clk expected done[1]"); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL zero_err: got %b expected 0", e); end
        checks++; if (starts != 0) begin failures++; $display("FAIL zero_start: got %0d expected 0", starts); end
    endtask

    task automatic test_timeout();
        int at = 0, cs_bad = 0;
        bit seen = 0;
        logic e = 1'b0;
        stall = 1'b1;
        req_cyc_count[0 +: Nc] = 6'd2;
        req[0] = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (gnt != 4'b0) seen = 1;
        end
        for (int c = 1; c <= 40 && at == 0; c++) begin
            @(negedge clk);
            if (spi_cs_n !== 4'hF) cs_bad++;
            if (done[0]) begin
                at = c;
                e = err;
                req[0] = 1'b0;
            end
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        checks++; if (at != WAIT_MAX + 2) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", at, WAIT_MAX + 2); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL timeout_err: got %b expected 1", e); end
        checks++; if (cs_bad != 0) begin failures++; $display("FAIL timeout_cs: got %0d bad cycles expected 0", cs_bad); end
    endtask

    task automatic test_reset_mid_run();
        int rdys = 0, dones = 0;
        bit busy_seen = 0;
        logic e = 1'b0;
        req_cyc_count[2*Nc +: Nc] = 6'd3;
        req_data_in[2*N +: N] = 8'h5A;
        req[2] = 1'b1;
        for (int c = 0; c < 40 && !busy_seen; c++) begin
            @(negedge clk);
            if (spi_cs_n[2] == 1'b0) busy_seen = 1;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL rstmid_gnt: got %b expected 0000", gnt); end
        checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL rstmid_cs: got %h expected f", spi_cs_n); end
        checks++; if ({done, err} !== 5'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 00000", {done, err}); end
        rst = 1'b0;
        for (int c = 0; c < 200 && dones == 0; c++) begin
            @(negedge clk);
            if (cl_data_rdy[2]) rdys++;
            if (done != 4'b0) begin
                dones++;
                e = err;
                if (!done[2]) dones += 10;
                req[2] = 1'b0;
            end
        end
        req = 4'h0;
        checks++; if (!busy_seen) begin failures++; $display("FAIL rstmid_busy: got no transfer expected one"); end
        checks++; if (dones != 1) begin failures++; $display("FAIL rstmid_after_done: got %0d expected 1", dones); end
        checks++; if (rdys != 3) begin failures++; $display("FAIL rstmid_after_rdy: got %0d expected 3", rdys); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rstmid_after_err: got %b expected 0", e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_zero_count();
        test_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
